board_keeper: RTL

Board state register and tile-spawn stage that closes the 2048 game loop. It holds the authoritative 4x4 board, which feeds the move engine and the display. It accepts each post-move board from the move engine, discards moves that change nothing, and inserts one new tile into a pseudo-randomly chosen empty cell. After reset it seeds the board with two tiles.

---
 rtl/board_keeper.sv | 112 +++++++++++
 1 files changed

// File: rtl/board_keeper.sv
// 2048 board state register: accepts post-move boards, rejects no-op moves,
// and spawns one tile into a pseudo-randomly chosen empty cell.
module board_keeper #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_valid,
    input  logic [63:0]      move_board,
    output logic [63:0]      slots,
    output logic             busy,
    output logic             spawned,
    output logic             no_change,
    output logic             board_full,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [1:0] {IDLE, LATCH, SCAN} state_t;

    state_t      state, state_nx;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [1:0]  pending;
    logic [3:0]  start_idx;
    logic [3:0]  scan_off;
    logic [3:0]  cell_idx;
    logic [3:0]  cell_val;
    logic        four_sel;
    logic        accept;
    logic        reject;
    logic        hit;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cell_idx = start_idx + scan_off;
    assign cell_val = slots[{cell_idx, 2'b00} +: 4];
    assign accept   = (state == IDLE) && move_valid && (move_board != slots);
    assign reject   = (state == IDLE) && move_valid && (move_board == slots);
    assign hit      = (state == SCAN) && (cell_val == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= LATCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = LATCH;
            LATCH: state_nx = SCAN;
            SCAN: begin
                // pending > 1 means another spawn is still owed after this one
                if (hit)                   state_nx = (pending > 2'd1) ? LATCH : IDLE;
                else if (scan_off == 4'hF) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        board_full = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            if (slots[4*i +: 4] == 4'd0) board_full = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots      <= '0;
            spawned    <= 1'b0;
            no_change  <= 1'b0;
            move_count <= '0;
            lfsr       <= SEED;
            pending    <= 2'd2;
            start_idx  <= '0;
            scan_off   <= '0;
            four_sel   <= 1'b0;
        end else begin
            lfsr      <= (lfsr == 16'd0) ? SEED : {lfsr[14:0], lfsr_fb};
            spawned   <= 1'b0;
            no_change <= reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        slots   <= move_board;
                        pending <= 2'd1;
                        if (move_count != '1) move_count <= move_count + 1'b1;
                    end
                end
                LATCH: begin
                    start_idx <= lfsr[3:0];
                    four_sel  <= (lfsr[7:4] == 4'd0);
                    scan_off  <= '0;
                end
                SCAN: begin
                    if (hit) begin
                        slots[{cell_idx, 2'b00} +: 4] <= four_sel ? 4'd2 : 4'd1;
                        spawned <= 1'b1;
                        pending <= pending - 2'd1;
                    end else if (scan_off == 4'hF) begin
                        pending <= 2'd0;
                    end else begin
                        scan_off <= scan_off + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
